// File: rtl/regfile_wb_arb.sv
// Writeback arbiter and register scoreboard.
// Three writeback requesters share one register-file write port under
// round-robin arbitration. A pending-bit scoreboard tracks destinations
// reserved at issue so read operands can be marked busy until written back.
module regfile_wb_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [DATA_W-1:0] req_data_0,
  output logic              req_ready_0,
  input  logic              req_valid_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_data_1,
  output logic              req_ready_1,
  input  logic              req_valid_2,
  input  logic [ADDR_W-1:0] req_addr_2,
  input  logic [DATA_W-1:0] req_data_2,
  output logic              req_ready_2,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wb_err
);

  logic [2:0]        valid;
  logic [2:0]        grant;
  logic              xfer;
  logic [1:0]        win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [2:0]        cand_sum;
  logic [1:0]        cand;

  logic [1:0]        ptr_q,     ptr_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] waddr_q,   waddr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              err_q,     err_d;
  logic              rsv_hit;

  assign valid = {req_valid_2, req_valid_1, req_valid_0};

  // Round-robin search from ptr_q: first valid requester in ptr, ptr+1, ptr+2 (mod 3) wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    grant    = '0;
    xfer     = 1'b0;
    win_idx  = 2'd0;
    cand_sum = 3'd0;
    cand     = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand_sum = {1'b0, ptr_q} + 3'(k);
      if (cand_sum >= 3'd3) cand_sum = cand_sum - 3'd3;
      cand = cand_sum[1:0];
      if (!xfer && valid[cand]) begin
        grant[cand] = 1'b1;
        xfer        = 1'b1;
        win_idx     = cand;
      end
    end
    if (rst) begin
      grant = '0;
      xfer  = 1'b0;
    end
  end

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];
  assign req_ready_2 = grant[2];

  assign win_addr = (win_idx == 2'd0) ? req_addr_0 :
                    (win_idx == 2'd1) ? req_addr_1 : req_addr_2;
  assign win_data = (win_idx == 2'd0) ? req_data_0 :
                    (win_idx == 2'd1) ? req_data_1 : req_data_2;

  // A reservation landing on the winner's address at the same edge keeps it pending and legal.
  assign rsv_hit = rsv_valid && (rsv_addr != '0) && (rsv_addr == win_addr);

  // Next-state for pointer, write port, scoreboard and sticky error.
  always_comb begin
    ptr_d     = ptr_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pending_d = pending_q;
    err_d     = err_q;
    if (xfer) begin
      ptr_d   = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
      we_d    = (win_addr != '0);
      waddr_d = win_addr;
      wdata_d = win_data;
      if (win_addr != '0) begin
        if (!pending_q[win_addr] && !rsv_hit) err_d = 1'b1;
        pending_d[win_addr] = 1'b0;
      end
    end
    // Set after clear so a same-edge reservation wins.
    if (rsv_valid && rsv_addr != '0) pending_d[rsv_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard is a flop vector, not a RAM, so it can and must be cleared on reset.
      ptr_q     <= 2'd0;
      pending_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
    end
  end

  assign busy1  = pending_q[raddr1];
  assign busy2  = pending_q[raddr2];
  assign we     = we_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign wb_err = err_q;

endmodule
